// File: rtl/darkbus_sram_resp.sv
// Word-addressed on-chip SRAM target on the darkbus handshake.
// Decodes its own address window, inserts WAIT_STATES cycles, pulses valid once per request.
module darkbus_sram_resp #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        res,
  input  logic        bus_en,
  input  logic        bus_rw,
  input  logic [3:0]  bus_be,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rdata_oe,
  output logic        bus_valid,
  output logic        busy
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS) * 32'd4;
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic            r_valid;
  logic            r_oe;
  logic            r_busy;
  logic [31:0]     r_rdata;

  logic            r_rw;
  logic [3:0]      r_be;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic [31:0]     w_off;
  logic            w_hit;
  logic            w_accept;
  logic [AW-1:0]   w_idx;
  logic            w_rsp_rw;
  logic [AW-1:0]   w_rsp_idx;

  // Unsigned wrap makes addresses below BASE_ADDR land far outside the window.
  assign w_off    = bus_addr - BASE_ADDR;
  assign w_hit    = (w_off < SPAN);
  assign w_idx    = w_off[AW+1:2];
  assign w_accept = bus_en && w_hit;

  // With zero wait states RESP is entered straight from IDLE, before the capture registers load.
  assign w_rsp_rw  = (r_state == S_IDLE) ? bus_rw : r_rw;
  assign w_rsp_idx = (r_state == S_IDLE) ? w_idx  : r_idx;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_valid <= 1'b0;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_valid <= 1'b0;
      r_oe    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
              r_valid <= 1'b1;
              if (!w_rsp_rw) begin
                r_oe    <= 1'b1;
                r_rdata <= r_mem[w_rsp_idx];
              end
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_valid <= 1'b1;
            if (!w_rsp_rw) begin
              r_oe    <= 1'b1;
              r_rdata <= r_mem[w_rsp_idx];
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          // A held en must drop for a cycle before another request is taken.
          if (!bus_en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Request capture and the write commit at the end of RESP; storage is never reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_accept) begin
      r_rw    <= bus_rw;
      r_be    <= bus_be;
      r_idx   <= w_idx;
      r_wdata <= bus_wdata;
    end
    if (r_state == S_RESP && r_rw) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign bus_rdata    = r_rdata;
  assign bus_rdata_oe = r_oe;
  assign bus_valid    = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_darkbus_sram_resp.sv
// Bench for darkbus_sram_resp: five differently configured responders share one bus,
// each compared against a word-level memory model with window/latency rules.
module tb_darkbus_sram_resp;

  localparam int N = 5;
  localparam logic [N-1:0][31:0] P_BASE  = {32'h0, 32'h0, 32'h0, 32'h8000_0000, 32'h0};
  localparam logic [N-1:0][31:0] P_DEPTH = {32'd1024, 32'd1024, 32'd64, 32'd256, 32'd1024};
  localparam logic [N-1:0][31:0] P_WS    = {32'd3, 32'd15, 32'd0, 32'd2, 32'd1};

  logic        clk = 1'b0;
  logic        res;
  logic        bus_en;
  logic        bus_rw;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] rdata [N];
  logic [N-1:0] oe;
  logic [N-1:0] valid;
  logic [N-1:0] busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_mem [int];
  logic [31:0] m_last [N];
  bit          m_last_ok [N];
  logic [31:0] x_rd [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    darkbus_sram_resp #(
      .BASE_ADDR  (P_BASE[g]),
      .DEPTH_WORDS(int'(P_DEPTH[g])),
      .WAIT_STATES(int'(P_WS[g]))
    ) u_dut (
      .clk         (clk),
      .res         (res),
      .bus_en      (bus_en),
      .bus_rw      (bus_rw),
      .bus_be      (bus_be),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (rdata[g]),
      .bus_rdata_oe(oe[g]),
      .bus_valid   (valid[g]),
      .busy        (busy[g])
    );
  end

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  function automatic bit m_hit(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - P_BASE[d];
    return off < P_DEPTH[d] * 32'd4;
  endfunction

  function automatic int m_key(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - P_BASE[d];
    return d * 70000 + int'(off >> 2);
  endfunction

  task automatic m_write(input int k, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] w;
    if (m_mem.exists(k)) begin
      w = m_mem[k];
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
      m_mem[k] = w;
    end else if (be == 4'hF) begin
      m_mem[k] = wd;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < N; d++) begin
      check({tag, "_valid"}, d, 32'(valid[d]), 32'd0);
      check({tag, "_oe"},    d, 32'(oe[d]),    32'd0);
      check({tag, "_busy"},  d, 32'(busy[d]),  32'd0);
      check({tag, "_rdata"}, d, rdata[d],      32'd0);
    end
  endtask

  // One request held on the bus; abort_c>0 asserts reset after that many sampled cycles.
  task automatic xact(input bit rw, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wd, input int abort_c);
    int  vcnt [N];
    int  vcyc [N];
    bit  hit  [N];
    int  key  [N];
    int  last_c;
    last_c = (abort_c > 0) ? abort_c : 20;
    bus_en = 1'b1; bus_rw = rw; bus_be = be; bus_addr = addr; bus_wdata = wd;
    for (int d = 0; d < N; d++) begin
      vcnt[d] = 0; vcyc[d] = 0;
      hit[d] = m_hit(d, addr);
      key[d] = m_key(d, addr);
    end
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        check("oe_only_read_valid", d, 32'(oe[d]), 32'(valid[d] & ~rw));
        if (valid[d]) begin
          vcnt[d]++;
          if (vcyc[d] == 0) begin
            vcyc[d] = c;
            x_rd[d] = rdata[d];
          end
        end
        if (c == 1 || c == 20) check("busy", d, 32'(busy[d]), 32'(hit[d]));
      end
    end
    if (abort_c > 0) begin
      res = 1'b1;
      #1;
      check_zero("abort");
      for (int d = 0; d < N; d++) begin
        check("abort_valid_cnt", d, 32'(vcnt[d]), 32'(hit[d] && (int'(P_WS[d]) + 1 <= abort_c)));
        if (hit[d] && rw && (int'(P_WS[d]) + 2 <= abort_c)) m_write(key[d], be, wd);
        m_last[d] = 32'd0; m_last_ok[d] = 1'b1;
      end
      @(negedge clk);
      res = 1'b0; bus_en = 1'b0;
      @(negedge clk);
    end else begin
      bus_en = 1'b0;
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
        check("busy_after_hold", d, 32'(busy[d]), 32'd0);
        check("valid_cnt", d, 32'(vcnt[d]), 32'(hit[d]));
        if (hit[d]) begin
          check("latency", d, 32'(vcyc[d]), P_WS[d] + 32'd1);
          if (rw) begin
            m_write(key[d], be, wd);
          end else if (m_mem.exists(key[d])) begin
            check("rdata", d, x_rd[d], m_mem[key[d]]);
            m_last[d] = m_mem[key[d]]; m_last_ok[d] = 1'b1;
          end else begin
            m_last_ok[d] = 1'b0;
          end
        end
        if (m_last_ok[d]) check("rdata_hold", d, rdata[d], m_last[d]);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    res = 1'b1; bus_en = 1'b0; bus_rw = 1'b0; bus_be = 4'h0; bus_addr = 32'h0; bus_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    for (int d = 0; d < N; d++) begin m_last[d] = 32'd0; m_last_ok[d] = 1'b1; end
    res = 1'b0;
    @(negedge clk);

    xact(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 0);
    xact(1'b0, 4'hF, 32'h10, 32'h0, 0);
    check("rd_deadbeef", 0, x_rd[0], 32'hDEAD_BEEF);

    xact(1'b1, 4'hF, 32'h20, 32'h1122_3344, 0);
    xact(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, 0);
    xact(1'b0, 4'hF, 32'h20, 32'h0, 0);
    check("rd_byte_en", 0, x_rd[0], 32'h11BB_33DD);
    xact(1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 0);
    xact(1'b0, 4'hF, 32'h20, 32'h0, 0);
    check("rd_be_zero", 0, x_rd[0], 32'h11BB_33DD);

    xact(1'b1, 4'hF, 32'h8000_03FC, 32'h0BAD_CAFE, 0);
    xact(1'b0, 4'hF, 32'h8000_03FC, 32'h0, 0);
    check("rd_top_word", 1, x_rd[1], 32'h0BAD_CAFE);
    xact(1'b0, 4'hF, 32'h8000_0400, 32'h0, 0);
    xact(1'b0, 4'hF, 32'h7FFF_FFFC, 32'h0, 0);
    xact(1'b1, 4'hF, 32'h8000_0013, 32'h4444_4444, 0);
    xact(1'b0, 4'hF, 32'h8000_0010, 32'h0, 0);
    check("rd_word4", 1, x_rd[1], 32'h4444_4444);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      a = 32'($urandom_range(0, 79)) * 32'd4 + 32'($urandom_range(0, 3));
      else if (sel == 1) a = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      else               a = $urandom;
      xact(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, 0);
    end

    xact(1'b1, 4'hF, 32'h40, 32'h1234_5678, 0);
    xact(1'b1, 4'hF, 32'h40, 32'hCAFE_F00D, 3);
    xact(1'b0, 4'hF, 32'h40, 32'h0, 0);
    check("rd_after_abort", 4, x_rd[4], 32'h1234_5678);
    check("rd_committed_ws1", 0, x_rd[0], 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/darkbus_sram_resp.md
Name: darkbus_sram_resp

Overview:
- Responder (target) end of the darkbus handshake: en, rw, be, addr, data, valid.
- Sits behind the memory mapper as an on-chip word-addressed SRAM region.
- Serves fetch reads and load/store traffic from the core with a configurable number of wait states.
- Decodes its own address window and stays silent on misses, so other targets can answer.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be DEPTH_WORDS*4 aligned.
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, 16..65536.
- WAIT_STATES, 1: extra cycles between request acceptance and valid; 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- res  in  1  reset, asynchronous, active-high.
- bus_en  in  1  request from initiator; held high with stable rw/be/addr/wdata until valid is seen.
- bus_rw  in  1  1 = write (initiator drives data), 0 = read.
- bus_be  in  4  byte enables for writes; bit i covers data[8i+7:8i]; ignored on reads.
- bus_addr  in  32  byte address; bits [1:0] ignored (word access).
- bus_wdata  in  32  write data, the initiator-driven side of the shared data line.
- bus_rdata  out  32  read data.
- bus_rdata_oe  out  1  drive enable for the shared data line; the wrapper tristates bus_rdata when 0.
- bus_valid  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release) forces state IDLE and all of the following to 0: bus_valid, bus_rdata_oe, bus_rdata, busy, wait counter. SRAM contents are not reset.
- Hit: (bus_addr - BASE_ADDR) < DEPTH_WORDS*4, computed unsigned at 32 bits. Word index = offset[log2(DEPTH_WORDS)+1:2].
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - bus_en=1 and hit: capture rw, be, index, wdata into internal registers. Go to WAIT if WAIT_STATES>0 (counter := WAIT_STATES-1), otherwise go to RESP.
  - bus_en=1 and miss: remain in IDLE, no response.
- WAIT: counter decrements each cycle; at 0, go to RESP. Later input changes are ignored; the captured request is used.
- RESP, exactly one cycle:
  - bus_valid=1.
  - Read: bus_rdata = mem[index] as sampled at the RESP edge, and bus_rdata_oe=1 in this cycle only.
  - Write: mem[index] bytes with be[i]=1 are updated at the end of RESP; bytes with be[i]=0 are unchanged; be=4'b0000 still completes with valid.
  - Next state is HOLD.
- HOLD: waits for bus_en=0, then goes to IDLE. This prevents a held en from being re-accepted as a second request. A new request needs at least one cycle with en low.
- Latency: request first seen in IDLE at edge T gives bus_valid high in cycle T+1+WAIT_STATES.
- bus_rdata holds its last read value after RESP. It changes only on read completion or reset. bus_rdata_oe is 0 outside read-RESP cycles.
- Read-after-write to the same word returns the new data; the write commits before any later RESP can sample it.
- Reset during WAIT or RESP: the transaction is aborted. A write is not committed if reset asserts before the RESP clock edge.
- Address wrap: with BASE_ADDR near the top of the space, addresses below BASE_ADDR miss, because the subtraction wraps to a large value.
- Initiator dropping en mid-WAIT is a protocol violation. The responder still completes the captured transaction and pulses valid.

Test Plan:
- Write then read back, WAIT_STATES=1, BASE=0:
  - Write addr 0x10, be=1111, data 0xDEADBEEF, en held -> valid exactly 2 cycles after en is sampled.
  - Drop en, then read 0x10 -> rdata=0xDEADBEEF with rdata_oe=1 in the valid cycle only.
- Byte enables:
  - Write 0x11223344 to 0x20, then write be=0101 data 0xAABBCCDD -> read returns 0x11BB33DD.
  - Write be=0000 -> valid pulses, word unchanged.
- Address decode, BASE=0x8000_0000, DEPTH=256:
  - Read 0x8000_03FC -> valid.
  - Reads 0x8000_0400 and 0x7FFF_FFFC -> no valid for 20 cycles, state stays IDLE.
  - Addr 0x8000_0013 accesses word 4.
- Held en:
  - en kept high for 10 cycles after valid -> exactly one valid pulse.
  - en low for 1 cycle then high -> second valid.
- WAIT_STATES=0 and WAIT_STATES=15 -> valid at T+1 and T+16; busy high from T+1 through the HOLD exit.
- Reset mid-write:
  - WAIT_STATES=3, write 0xCAFEF00D to 0x40 over old 0x12345678, assert res in WAIT -> outputs 0 immediately.
  - After release, read 0x40 -> 0x12345678.
